// File: rtl/icache_req_arb_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_req_arb_mc_if
//  Purpose  : Bundles the request-side, MSHR-allocation and tag-request
//             handshakes of the N-channel icache request arbiter.
//  Signals  : ch_enable/req_vld/req_pld  -> per-channel requests (in to arb)
//             req_rdy                    -> per-channel accept (one-hot/zero)
//             alloc_vld/alloc_rdy/alloc_index -> MSHR allocation handshake
//             tag_req_*                  -> registered request to tag array
//  Modports : slave  - arbiter view
//             master - environment view (sources, MSHR, tag controller)
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_req_arb_mc_if #(
  parameter int NUM_CH    = 3,
  parameter int PLD_WIDTH = 64,
  parameter int IDX_WIDTH = 3
);
  localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]           ch_enable;
  logic [NUM_CH-1:0]           req_vld;
  logic [NUM_CH-1:0]           req_rdy;
  logic [NUM_CH*PLD_WIDTH-1:0] req_pld;

  logic                        alloc_vld;
  logic                        alloc_rdy;
  logic [IDX_WIDTH-1:0]        alloc_index;

  logic                        tag_req_vld;
  logic                        tag_req_rdy;
  logic [PLD_WIDTH-1:0]        tag_req_pld;
  logic [IDX_WIDTH-1:0]        tag_req_index;
  logic [c_CH_W-1:0]           tag_req_ch;

  modport slave (
    input  ch_enable, req_vld, req_pld, alloc_rdy, alloc_index, tag_req_rdy,
    output req_rdy, alloc_vld, tag_req_vld, tag_req_pld, tag_req_index,
           tag_req_ch
  );

  modport master (
    output ch_enable, req_vld, req_pld, alloc_rdy, alloc_index, tag_req_rdy,
    input  req_rdy, alloc_vld, tag_req_vld, tag_req_pld, tag_req_index,
           tag_req_ch
  );
endinterface
`default_nettype wire

// File: rtl/icache_req_arb_mc.sv
`default_nettype none
// ============================================================================
//  Module   : icache_req_arb_mc
//  Purpose  : N-channel icache request arbiter. Grants at most one eligible
//             channel per cycle, strobes an MSHR allocation and registers the
//             winning payload, MSHR index and channel id into a one-entry
//             tag-request stage.
//             Winner priority: starved round-robin channels (lowest index),
//             then fixed-priority channels (lowest index), then round-robin.
//  Ports    : clk   - clock
//             rst_n - asynchronous active-low reset
//             bus   - icache_req_arb_mc_if.slave (requests, MSHR alloc,
//                     tag request)
//  Revision : 1.0 - initial release
// ============================================================================
module icache_req_arb_mc #(
  parameter int                   NUM_CH       = 3,
  parameter int                   PLD_WIDTH    = 64,
  parameter int                   IDX_WIDTH    = 3,
  parameter logic [NUM_CH-1:0]    HP_MASK      = 3'b001,
  parameter int                   STARVE_LIMIT = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  icache_req_arb_mc_if.slave   bus
);

  localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CH_W-1:0]  c_LAST  = c_CH_W'(NUM_CH - 1);

  generate
    if (NUM_CH < 2) begin : g_bad_num_ch
      $error("icache_req_arb_mc: NUM_CH must be at least 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("icache_req_arb_mc: STARVE_LIMIT must be at least 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_CH_W-1:0]               r_rr_ptr;
  logic [NUM_CH-1:0][c_CNT_W-1:0]  r_cnt;
  logic                            r_tag_vld;
  logic [PLD_WIDTH-1:0]            r_tag_pld;
  logic [IDX_WIDTH-1:0]            r_tag_index;
  logic [c_CH_W-1:0]               r_tag_ch;

  // --------------------------------------------------------------------------
  // Eligibility and grant condition
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_starved;
  logic              w_slot_free;
  logic              w_fire;

  assign w_elig = bus.req_vld & bus.ch_enable;

  // Stage is reusable when empty or being drained this cycle; this bypass
  // is what allows a grant every cycle under continuous tag acceptance.
  assign w_slot_free = !r_tag_vld || bus.tag_req_rdy;

  // rst_n gates the combinational handshakes so nothing is accepted while
  // the registered side is held in reset.
  assign w_fire = rst_n && (|w_elig) && bus.alloc_rdy && w_slot_free;

  // Only round-robin channels can be starved; fixed-priority channels never
  // carry a counter.
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!HP_MASK[i] && w_elig[i] && (r_cnt[i] == c_LIMIT)) begin
        w_starved[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  logic [c_CH_W-1:0] w_win;
  logic              w_win_rr;     // winner came from the round-robin tier
  logic              w_found;

  always_comb begin
    w_win    = '0;
    w_win_rr = 1'b0;
    w_found  = 1'b0;

    // Tier 1: starved channels, lowest index first.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && w_starved[i]) begin
        w_win   = c_CH_W'(i);
        w_found = 1'b1;
      end
    end

    // Tier 2: fixed-priority channels, lowest index first.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && HP_MASK[i] && w_elig[i]) begin
        w_win   = c_CH_W'(i);
        w_found = 1'b1;
      end
    end

    // Tier 3: round-robin search starting at the pointer, wrapping.
    for (int k = 0; k < NUM_CH; k++) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      if (!w_found && !HP_MASK[j] && w_elig[j]) begin
        w_win    = c_CH_W'(j);
        w_win_rr = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake outputs
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_grant;

  always_comb begin
    w_grant = '0;
    if (w_fire) begin
      w_grant[w_win] = 1'b1;
    end
  end

  assign bus.req_rdy   = w_grant;
  assign bus.alloc_vld = w_fire;

  // --------------------------------------------------------------------------
  // Round-robin pointer: advances past the winner only on tier-3 wins so
  // promoted or fixed-priority wins do not disturb the rotation.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_fire && w_win_rr) begin
      r_rr_ptr <= (w_win == c_LAST) ? '0 : w_win + c_CH_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counters. Leaving the eligible set (invalid or disabled)
  // clears the count regardless of fire; otherwise counts only move on
  // fire cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (HP_MASK[i] || !w_elig[i]) begin
          r_cnt[i] <= '0;
        end else if (w_fire) begin
          if (w_grant[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] != c_LIMIT) begin
            r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // One-entry tag-request stage. Contents change only on a grant, so they
  // hold still under back-pressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld   <= 1'b0;
      r_tag_pld   <= '0;
      r_tag_index <= '0;
      r_tag_ch    <= '0;
    end else if (w_fire) begin
      r_tag_vld   <= 1'b1;
      r_tag_pld   <= bus.req_pld[w_win*PLD_WIDTH +: PLD_WIDTH];
      r_tag_index <= bus.alloc_index;
      r_tag_ch    <= w_win;
    end else if (bus.tag_req_rdy) begin
      r_tag_vld   <= 1'b0;
    end
  end

  assign bus.tag_req_vld   = r_tag_vld;
  assign bus.tag_req_pld   = r_tag_pld;
  assign bus.tag_req_index = r_tag_index;
  assign bus.tag_req_ch    = r_tag_ch;

endmodule
`default_nettype wire

// File: doc/icache_req_arb_mc.md
Name: icache_req_arb_mc

Overview:
- Parametrised N-channel successor to the icache request arbiter. Sits between the request sources (downstream snoop, upstream fetch, prefetch, and any added sources) and the tag array controller.
- Each cycle it grants at most one channel, pulses an MSHR allocation, and registers the winning payload with its MSHR index into a one-entry tag-request stage.
- Arbitration is mixed: fixed priority for masked channels, round-robin for the rest, plus starvation promotion and per-channel enables.

Parameters:
- NUM_CH, 3, number of request channels (min 2).
- PLD_WIDTH, 64, width of one pc_req_t payload in bits.
- IDX_WIDTH, 3, MSHR entry index width.
- HP_MASK, 3'b001, bit i=1 puts channel i in the fixed-priority group (lower index wins).
- STARVE_LIMIT, 8, consecutive lost cycles before a round-robin channel is promoted (min 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_enable  in  NUM_CH  per-channel enable; a disabled channel is never granted.
- req_vld  in  NUM_CH  per-channel request valid.
- req_rdy  out  NUM_CH  per-channel accept; one-hot or zero.
- req_pld  in  NUM_CH*PLD_WIDTH  channel i payload at bits [i*PLD_WIDTH +: PLD_WIDTH].
- alloc_vld  out  1  MSHR allocation strobe; equals grant fire.
- alloc_rdy  in  1  MSHR has a free entry.
- alloc_index  in  IDX_WIDTH  free entry index, valid while alloc_rdy=1.
- tag_req_vld  out  1  tag request valid (registered).
- tag_req_rdy  in  1  tag array accepts.
- tag_req_pld  out  PLD_WIDTH  registered winning payload.
- tag_req_index  out  IDX_WIDTH  registered MSHR index.
- tag_req_ch  out  $clog2(NUM_CH)  registered winning channel id.

Behaviour:
- Reset is asynchronous. On reset: tag_req_vld=0; tag_req_pld, tag_req_index and tag_req_ch are all 0; RR pointer=0; all starvation counters=0.
- Combinational outputs req_rdy and alloc_vld are 0 while rst_n=0.
- Eligible set: E = req_vld & ch_enable.
- Stage free: slot_free = !tag_req_vld | tag_req_rdy. This gives a full-throughput bypass; back-to-back grants every cycle are allowed.
- Grant condition: fire = (|E) & alloc_rdy & slot_free. No grant when fire=0; in that case req_rdy=0 and alloc_vld=0.
- Winner selection, in priority order:
  1. Starved channels (counter == STARVE_LIMIT). Among these, the lowest index wins.
  2. HP_MASK channels in E. The lowest index wins.
  3. Non-HP channels in E. Round-robin: first index at or after the RR pointer, wrapping modulo NUM_CH.
- On fire:
  - req_rdy[w]=1 and alloc_vld=1 in the same cycle.
  - Next edge: tag_req_vld=1, tag_req_pld=req_pld[w], tag_req_index=alloc_index, tag_req_ch=w.
- RR pointer: updates to (w+1) mod NUM_CH only when the winner came from tier 3. Tier 1 and tier 2 wins leave it unchanged.
- Starvation counter, per non-HP channel i:
  - Increments, saturating at STARVE_LIMIT, on each fire cycle where i is in E and i is not the winner.
  - Clears when i wins, or when req_vld[i]=0.
  - Holds on cycles with fire=0.
  - HP channels have no counter.
- Output stage: on tag_req_vld & tag_req_rdy with no new fire, tag_req_vld goes to 0 next edge. With a simultaneous fire, the register reloads and tag_req_vld stays 1.
- Payload stability: while tag_req_vld=1 and tag_req_rdy=0, all tag_req_* outputs hold stable.
- Source-side rule: a requester must hold req_vld and req_pld stable until req_rdy. The arbiter does not check this.
- Channel disable: ch_enable[i] dropping while req_vld[i]=1 removes i from E immediately. Its counter clears, since it is treated as not requesting.
- alloc_rdy=0: no grant. Counters hold. An already-registered tag request still drains normally.

Test Plan:
- Single channel: NUM_CH=3. Ch1 only, alloc_rdy=1, alloc_index=5, tag_req_rdy=1 → req_rdy[1]=1 and alloc_vld=1 in cycle 0. In cycle 1: tag_req_vld=1, tag_req_index=5, tag_req_ch=1, payload matches.
- Fixed priority vs round-robin: all three channels valid continuously, tag_req_rdy=1 → grant order 0,0,0,… to start. Then deassert ch0 → grants alternate 1,2,1,2.
- Starvation: STARVE_LIMIT=2. Ch0 (HP) and ch2 held valid, ch1 off → ch0 wins 2 cycles. Ch2 counter reaches 2 and ch2 wins cycle 2. Counter clears; ch0 wins cycles 3–4.
- Backpressure: tag_req_rdy=0 for 4 cycles with ch1 valid → one grant, then req_rdy=0 and alloc_vld=0 while outputs are stable. tag_req_rdy=1 → handoff and a new grant in the same cycle.
- MSHR full: alloc_rdy=0 with all channels valid → no req_rdy and no alloc_vld for 5 cycles, counters unchanged. alloc_rdy=1 → grant resumes.
- Reset mid-operation: assert rst_n=0 asynchronously while tag_req_vld=1 → tag_req_vld=0 immediately. After release, the RR pointer restarts at ch0: a ch1/ch2 contention grants ch1 first.
